// File: rtl/eco32f_serdiv_if.sv
// Handshake and operand/result bundle for the eco32f_serdiv iterative divider.
// The master side drives requests; the slave side is the divider itself.
interface eco32f_serdiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             kill;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, kill, signed_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, kill, signed_op, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/eco32f_serdiv.sv
// Radix-2 restoring divider, one quotient bit per cycle, signed/unsigned, with kill.
// Optional leading-zero skip of the dividend: define ECO32F_SERDIV_EARLY_OUT_EN.
module eco32f_serdiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic          clk,
    input logic          rst,
    eco32f_serdiv_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOAD, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_raw, n_q, d_q, r_q;
    logic [WIDTH-1:0] q_out, r_out;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_q, neg_r, dz_out;
    logic             accept, last_iter, load_skip;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] r_sub, r_nxt, n_nxt;
    logic             diff_ok;

    function automatic logic [WIDTH-1:0] mag(input logic s, input logic [WIDTH-1:0] v);
        return (s && v[WIDTH-1]) ? -v : v;
    endfunction

    assign accept    = (state_q == IDLE || state_q == DONE) && bus.start && !bus.kill;
    assign last_iter = (state_q == BUSY) && (cnt_q == CNT_W'(1));

    // The shifted partial remainder needs WIDTH+1 bits: with a divisor near 2^WIDTH
    // the remainder can use its top bit before the shift.
    assign shifted = {r_q, n_q[WIDTH-1]};
    assign diff_ok = (shifted >= {1'b0, d_q});
    assign r_sub   = WIDTH'(shifted - {1'b0, d_q});
    assign r_nxt   = diff_ok ? r_sub : shifted[WIDTH-1:0];
    assign n_nxt   = {n_q[WIDTH-2:0], diff_ok};

`ifdef ECO32F_SERDIV_EARLY_OUT_EN
    logic [CNT_W-1:0] lz;

    function automatic logic [CNT_W-1:0] clz(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) c = CNT_W'(WIDTH - 1 - i);
        end
        return c;
    endfunction

    assign lz        = clz(n_q);
    assign load_skip = (n_q == '0);
`else
    assign load_skip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: combinational logic uses blocking '=' and assigns every output a default
    // before any branch, so no latch is inferred; clocked state always uses '<='.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = LOAD;
            LOAD:    state_d = (d_q == '0 || load_skip) ? DONE : BUSY;
            BUSY:    if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE:    state_d = accept ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.kill) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_raw  <= '0;
            n_q    <= '0;
            d_q    <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            q_out  <= '0;
            r_out  <= '0;
            dz_out <= 1'b0;
        end else begin
            if (accept) begin
                x_raw <= bus.dividend;
                n_q   <= mag(bus.signed_op, bus.dividend);
                d_q   <= mag(bus.signed_op, bus.divisor);
                neg_q <= bus.signed_op & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                neg_r <= bus.signed_op & bus.dividend[WIDTH-1];
            end

            if (state_q == LOAD) begin
                r_q <= '0;
`ifdef ECO32F_SERDIV_EARLY_OUT_EN
                n_q   <= n_q << lz;
                cnt_q <= CNT_W'(WIDTH) - lz;
`else
                cnt_q <= CNT_W'(WIDTH);
`endif
                // A killed operation must leave the previous results untouched.
                if (!bus.kill) begin
                    if (d_q == '0) begin
                        q_out  <= '1;
                        r_out  <= x_raw;
                        dz_out <= 1'b1;
                    end else if (load_skip) begin
                        q_out  <= '0;
                        r_out  <= '0;
                        dz_out <= 1'b0;
                    end
                end
            end

            if (state_q == BUSY) begin
                r_q   <= r_nxt;
                n_q   <= n_nxt;
                cnt_q <= cnt_q - CNT_W'(1);
                if (last_iter && !bus.kill) begin
                    q_out  <= neg_q ? -n_nxt : n_nxt;
                    r_out  <= neg_r ? -r_nxt : r_nxt;
                    dz_out <= 1'b0;
                end
            end
        end
    end

    assign bus.busy        = (state_q == LOAD) || (state_q == BUSY);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = q_out;
    assign bus.remainder   = r_out;
    assign bus.div_by_zero = dz_out;

endmodule

// File: tb/tb_eco32f_serdiv.sv
// Self-checking bench for eco32f_serdiv: scoreboard of expected results and done cycles.
// Honours ECO32F_SERDIV_EARLY_OUT_EN for the expected latency.
module tb_eco32f_serdiv;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   last_done_cyc = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    eco32f_serdiv_if #(.WIDTH(W)) bus ();

    eco32f_serdiv #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int lat_of(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] m;
        int lz;
        if (b == '0) return 2;
        m = (s && a[W-1]) ? -a : a;
`ifdef ECO32F_SERDIV_EARLY_OUT_EN
        if (m == '0) return 2;
        lz = 0;
        while (lz < W && !m[W-1-lz]) lz++;
        return W - lz + 2;
`else
        lz = 0;
        if (m[0] === 1'bx) lz = 1;
        return W + 2 + lz;
`endif
    endfunction

    function automatic exp_t model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.dz = 1'b0;
        e.due = 0;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.dz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = a;
            e.r = '0;
        end else if (s) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst && bus.done) begin
            done_cnt++;
            last_done_cyc = cyc;
            if (sb.size() == 0) begin
                check("spurious_done", bus.done, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", bus.quotient, e.q);
                check("remainder", bus.remainder, e.r);
                check("div_by_zero", bus.div_by_zero, e.dz);
                check("done_cycle", cyc, e.due);
            end
        end
    end

    // Pulse start for one cycle; called #1 after a rising edge.
    task automatic send(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit track, input logic [W-1:0] q, input logic [W-1:0] r,
                        input logic dz);
        exp_t e;
        bus.start     = 1'b1;
        bus.signed_op = s;
        bus.dividend  = a;
        bus.divisor   = b;
        if (track) begin
            e.q   = q;
            e.r   = r;
            e.dz  = dz;
            e.due = cyc + lat_of(s, a, b);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic send_model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e = model(s, a, b);
        send(s, a, b, 1'b1, e.q, e.r, e.dz);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic check_all_zero();
        check("zero_busy", bus.busy, 1'b0);
        check("zero_done", bus.done, 1'b0);
        check("zero_quotient", bus.quotient, '0);
        check("zero_remainder", bus.remainder, '0);
        check("zero_div_by_zero", bus.div_by_zero, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, busy_cycles, dn;

        bus.start     = 1'b0;
        bus.kill      = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero();
        rst = 1'b1;
        @(negedge clk);
        check_all_zero();
        @(posedge clk);
        #1;

        // 100/7 unsigned: latency, busy length and results.
        c0 = cyc;
        send(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cycles++;
        end
        check("busy_cycles_100_7", busy_cycles, 33);
        check("latency_100_7", last_done_cyc - c0, lat_of(1'b0, 32'd100, 32'd7));
        drain();

        send(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        drain();
        send(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
        drain();

        c0 = cyc;
        send(1'b0, 32'h1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234, 1'b1);
        drain();
        check("latency_div0", last_done_cyc - c0, 2);

        // Kill during iteration 10: no done, busy drops, previous results kept.
        dn = done_cnt;
        send(1'b0, 32'd50, 32'd5, 1'b0, '0, '0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        @(negedge clk);
        check("kill_busy", bus.busy, 1'b0);
        check("kill_quotient", bus.quotient, 32'hFFFF_FFFF);
        check("kill_remainder", bus.remainder, 32'h1234);
        check("kill_div_by_zero", bus.div_by_zero, 1'b1);
        repeat (W + 5) @(posedge clk);
        #1;
        check("kill_no_done", done_cnt, dn);

        send(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
        drain();

        // Start while busy is ignored.
        dn = done_cnt;
        send(1'b0, 32'd1000, 32'd10, 1'b1, 32'd100, 32'd0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        send(1'b0, 32'd77, 32'd7, 1'b0, '0, '0, 1'b0);
        drain();
        repeat (W + 5) @(posedge clk);
        #1;
        check("busy_start_ignored", done_cnt, dn + 1);

        // Kill together with start is not accepted.
        dn = done_cnt;
        bus.kill = 1'b1;
        send(1'b0, 32'd9, 32'd3, 1'b0, '0, '0, 1'b0);
        bus.kill = 1'b0;
        @(negedge clk);
        check("kill_start_busy", bus.busy, 1'b0);
        repeat (W + 5) @(posedge clk);
        #1;
        check("kill_start_no_done", done_cnt, dn);

        // Back-to-back: start held high, second operation accepted in the DONE cycle.
        begin
            exp_t e;
            int lat_a;
            lat_a = lat_of(1'b0, 32'd100, 32'd7);
            bus.start     = 1'b1;
            bus.signed_op = 1'b0;
            bus.dividend  = 32'd100;
            bus.divisor   = 32'd7;
            e.q = 32'd14; e.r = 32'd2; e.dz = 1'b0; e.due = cyc + lat_a;
            sb.push_back(e);
            repeat (lat_a) @(posedge clk);
            #1;
            check("b2b_done_cycle", bus.done, 1'b1);
            bus.signed_op = 1'b1;
            bus.dividend  = 32'hFFFF_FF9C;
            bus.divisor   = 32'd7;
            e.q = 32'hFFFF_FFF2; e.r = 32'hFFFF_FFFE; e.dz = 1'b0;
            e.due = cyc + lat_of(1'b1, 32'hFFFF_FF9C, 32'd7);
            sb.push_back(e);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            drain();
        end

        // Asynchronous reset in the middle of BUSY.
        dn = done_cnt;
        send(1'b0, 32'd50, 32'd5, 1'b0, '0, '0, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_busy", bus.busy, 1'b0);
        repeat (W + 5) @(posedge clk);
        #1;
        check("post_reset_no_done", done_cnt, dn);

`ifdef ECO32F_SERDIV_EARLY_OUT_EN
        c0 = cyc;
        send(1'b0, 32'd3, 32'd1, 1'b1, 32'd3, 32'd0, 1'b0);
        drain();
        check("early_latency_3_1", last_done_cyc - c0, 4);
        send(1'b1, 32'd0, 32'd5, 1'b1, 32'd0, 32'd0, 1'b0);
        drain();
`endif

        // Random mix of signed/unsigned operands, including large and zero divisors.
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] a, b;
            bit s;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(1, 15));
                1: b = $urandom;
                2: b = (i == 2) ? 32'd0 : 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: b = 32'($urandom_range(0, 1000));
            endcase
            if (i == 5) a = 32'h0000_0001;
            send_model(s, a, b);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
